// File: rtl/tree_pkg.sv
// Shared definitions for the 7-node BST store (reader and insert/find blocks).
package tree_pkg;

    localparam int unsigned KEY_W = 4;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned NODES = 7;
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned SP_W  = $clog2(NODES + 1);

    localparam logic [IDX_W-1:0] NIL = IDX_W'(NODES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DESC,
        S_LWAIT,
        S_FETCH,
        S_KWAIT,
        S_EMIT,
        S_FIN
    } state_t;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [IDX_W-1:0] left;
        logic [IDX_W-1:0] right;
    } node_t;

    // Any slot index at or beyond NODES means "no child".
    function automatic logic is_nil(input logic [IDX_W-1:0] idx);
        return 32'(idx) >= NODES;
    endfunction

endpackage

// File: rtl/tree_inorder_reader_if.sv
// Node RAM read port plus the sorted-key output stream of the in-order reader.
interface tree_inorder_reader_if;
    import tree_pkg::*;

    logic             mem_rd_en;
    logic [IDX_W-1:0] mem_addr;
    logic [KEY_W-1:0] mem_key;
    logic [IDX_W-1:0] mem_left;
    logic [IDX_W-1:0] mem_right;
    logic             out_valid;
    logic             out_ready;
    logic [KEY_W-1:0] out_key;
    logic             out_last;

    modport master (
        output mem_rd_en, mem_addr, out_valid, out_key, out_last,
        input  mem_key, mem_left, mem_right, out_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, out_valid, out_key, out_last,
        output mem_key, mem_left, mem_right, out_ready
    );

endinterface

// File: rtl/tree_idx_stack.sv
// LIFO of node indices used in place of recursion by the in-order walk.
module tree_idx_stack
    import tree_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [IDX_W-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [IDX_W-1:0] top_c
);

    logic [IDX_W-1:0] mem [NODES];
    logic [SP_W-1:0]  sp;
    logic [SP_W-1:0]  sp_n;
    logic             do_push;

    assign do_push = push && !full && !clr;

    always_comb begin
        sp_n = sp;
        if (clr)
            sp_n = '0;
        else if (do_push)
            sp_n = sp + SP_W'(1);
        else if (pop && !empty)
            sp_n = sp - SP_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp    <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            sp    <= sp_n;
            full  <= (sp_n == SP_W'(NODES));
            empty <= (sp_n == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[sp] <= din;
    end

    // Reading an empty stack returns slot 0; the walker never pops when empty.
    assign top_c = empty ? mem[0] : mem[sp - SP_W'(1)];

endmodule

// File: rtl/tree_inorder_reader.sv
// In-order walk of the BST node RAM, streaming keys sorted over valid/ready.
// Optional TREE_RD_DESC_EN adds a desc input that mirrors the walk for descending order.
module tree_inorder_reader
    import tree_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IDX_W-1:0]      root_idx,
    input  logic [IDX_W-1:0]      node_count,
`ifdef TREE_RD_DESC_EN
    input  logic                  desc,
`endif
    tree_inorder_reader_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    state_t           state, state_n;
    logic [IDX_W-1:0] cur, cur_n, rnext, rnext_n, addr, addr_n;
    logic [CNT_W-1:0] emitted, emitted_n, emitted_inc, count_ext;
    logic [KEY_W-1:0] out_key, out_key_n;
    logic             out_valid, out_valid_n, out_last, out_last_n;
    logic             rd_en, rd_en_n, err_n, done_n, busy_n;
    logic             push, pop, clr, stk_full, stk_empty;
    logic [IDX_W-1:0] stk_top_c, child_l, child_r;
    node_t            rd_node;

    assign rd_node     = '{key: bus.mem_key, left: bus.mem_left, right: bus.mem_right};
    assign emitted_inc = emitted + CNT_W'(1);
    assign count_ext   = CNT_W'(node_count);

`ifdef TREE_RD_DESC_EN
    logic desc_q, desc_n;
    assign child_l = desc_q ? rd_node.right : rd_node.left;
    assign child_r = desc_q ? rd_node.left  : rd_node.right;
`else
    assign child_l = rd_node.left;
    assign child_r = rd_node.right;
`endif

    tree_idx_stack u_stack (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   (cur),
        .full  (stk_full),
        .empty (stk_empty),
        .top_c (stk_top_c)
    );

    always_comb begin
        state_n     = state;
        cur_n       = cur;
        rnext_n     = rnext;
        emitted_n   = emitted;
        out_key_n   = out_key;
        out_valid_n = out_valid;
        out_last_n  = out_last;
        err_n       = err;
        push        = 1'b0;
        pop         = 1'b0;
        clr         = 1'b0;
`ifdef TREE_RD_DESC_EN
        desc_n      = desc_q;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    cur_n     = root_idx;
                    clr       = 1'b1;
                    emitted_n = '0;
                    err_n     = 1'b0;
`ifdef TREE_RD_DESC_EN
                    desc_n    = desc;
`endif
                    state_n   = (node_count == '0 || is_nil(root_idx)) ? S_FIN : S_DESC;
                end
            end
            S_DESC: begin
                if (!is_nil(cur))
                    state_n = S_LWAIT;
                else if (stk_empty)
                    state_n = S_FIN;
                else begin
                    pop     = 1'b1;
                    cur_n   = stk_top_c;
                    state_n = S_FETCH;
                end
            end
            S_LWAIT: begin
                if (stk_full) begin
                    err_n   = 1'b1;
                    state_n = S_FIN;
                end else begin
                    push    = 1'b1;
                    cur_n   = child_l;
                    state_n = S_DESC;
                end
            end
            S_FETCH: state_n = S_KWAIT;
            S_KWAIT: begin
                out_key_n   = rd_node.key;
                rnext_n     = child_r;
                out_valid_n = 1'b1;
                out_last_n  = (emitted_inc == count_ext);
                state_n     = S_EMIT;
            end
            S_EMIT: begin
                if (bus.out_ready) begin
                    out_valid_n = 1'b0;
                    out_last_n  = 1'b0;
                    emitted_n   = emitted_inc;
                    cur_n       = rnext;
                    // Cycle guard: more keys than nodes means the links loop.
                    if (emitted_inc > count_ext) begin
                        err_n   = 1'b1;
                        state_n = S_FIN;
                    end else
                        state_n = S_DESC;
                end
            end
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // RAM strobe and status are registered one cycle ahead of the state they belong to.
        rd_en_n = (state_n == S_DESC && !is_nil(cur_n)) || (state_n == S_FETCH);
        addr_n  = cur_n;
        busy_n  = (state_n != S_IDLE);
        done_n  = (state == S_FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cur       <= NIL;
            rnext     <= NIL;
            emitted   <= '0;
            out_key   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            rd_en     <= 1'b0;
            addr      <= '0;
`ifdef TREE_RD_DESC_EN
            desc_q    <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cur       <= cur_n;
            rnext     <= rnext_n;
            emitted   <= emitted_n;
            out_key   <= out_key_n;
            out_valid <= out_valid_n;
            out_last  <= out_last_n;
            err       <= err_n;
            done      <= done_n;
            busy      <= busy_n;
            rd_en     <= rd_en_n;
            addr      <= rd_en_n ? addr_n : '0;
`ifdef TREE_RD_DESC_EN
            desc_q    <= desc_n;
`endif
        end
    end

    assign bus.mem_rd_en = rd_en;
    assign bus.mem_addr  = addr;
    assign bus.out_valid = out_valid;
    assign bus.out_key   = out_key;
    assign bus.out_last  = out_last;

endmodule

// File: tb/tb_tree_inorder_reader.sv
// Bench for tree_inorder_reader: directed trees plus random BSTs and random corrupt link sets.
module tb_tree_inorder_reader;
    import tree_pkg::*;

`ifdef TREE_RD_DESC_EN
    localparam bit HAS_DESC = 1'b1;
`else
    localparam bit HAS_DESC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, desc_sel, busy, done, err;
    logic [2:0] root_idx, node_count;

    always #5 clk = ~clk;

    tree_inorder_reader_if bus();

    tree_inorder_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .root_idx   (root_idx),
        .node_count (node_count),
`ifdef TREE_RD_DESC_EN
        .desc       (desc_sel),
`endif
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int errors = 0;
    int checks = 0;

    logic [3:0] t_key   [8];
    logic [2:0] t_left  [8];
    logic [2:0] t_right [8];

    int ins_keys[$];
    int exp_q[$];          // key*2 + last
    bit exp_err;
    int got_q[$];
    bit got_err;
    int done_cyc, valid_cyc, unstable;

    // Node RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.mem_key   <= t_key[bus.mem_addr];
            bus.mem_left  <= t_left[bus.mem_addr];
            bus.mem_right <= t_right[bus.mem_addr];
        end
    end

    function automatic void clear_tree();
        for (int i = 0; i < 8; i++) begin
            t_key[i] = 4'd0; t_left[i] = 3'd7; t_right[i] = 3'd7;
        end
        ins_keys.delete();
    endfunction

    function automatic void bst_insert(input int slot, input int key);
        int p = 0;
        t_key[slot] = 4'(key);
        ins_keys.push_back(key);
        if (slot == 0) return;
        for (int g = 0; g < 8; g++) begin
            if (key < int'(t_key[p])) begin
                if (t_left[p] == 3'd7) begin t_left[p] = 3'(slot); return; end
                p = int'(t_left[p]);
            end else begin
                if (t_right[p] == 3'd7) begin t_right[p] = 3'(slot); return; end
                p = int'(t_right[p]);
            end
        end
    endfunction

    // Valid BST: the stream is simply every key sorted, last flag on the final one.
    function automatic void expect_sorted();
        int s[$];
        s = ins_keys;
        if (desc_sel) s.rsort(); else s.sort();
        exp_q.delete();
        for (int i = 0; i < s.size(); i++)
            exp_q.push_back(s[i] * 2 + ((i == s.size() - 1) ? 1 : 0));
        exp_err = 1'b0;
    endfunction

    // Arbitrary links: iterative in-order walk with depth limit and emission-count guard.
    function automatic void expect_walk(input int root, input int cnt);
        int stk[$];
        int cur, em;
        exp_q.delete();
        exp_err = 1'b0;
        if (cnt == 0 || root >= 7) return;
        cur = root;
        em  = 0;
        for (int g = 0; g < 64; g++) begin
            while (cur < 7) begin
                if (stk.size() == 7) begin exp_err = 1'b1; return; end
                stk.push_back(cur);
                cur = desc_sel ? int'(t_right[cur]) : int'(t_left[cur]);
            end
            if (stk.size() == 0) return;
            cur = stk.pop_back();
            exp_q.push_back(int'(t_key[cur]) * 2 + ((em + 1 == cnt) ? 1 : 0));
            em++;
            if (em > cnt) begin exp_err = 1'b1; return; end
            cur = desc_sel ? int'(t_left[cur]) : int'(t_right[cur]);
        end
    endfunction

    function automatic void build_balanced();
        clear_tree();
        bst_insert(0, 4); bst_insert(1, 2); bst_insert(2, 6); bst_insert(3, 1);
        bst_insert(4, 3); bst_insert(5, 5); bst_insert(6, 7);
        root_idx = 3'd0; node_count = 3'd7;
    endfunction

    // Starts a walk and collects the stream until done; mode 0 ready always, 1 one-of-three, 2 random.
    task automatic run_walk(input int mode, input int inject_at);
        bit hold = 1'b0;
        bit rdy;
        logic [3:0] hk;
        logic hl;
        got_q.delete();
        got_err = 1'b0; done_cyc = -1; valid_cyc = -1; unstable = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 600; c++) begin
            if (hold && (!bus.out_valid || bus.out_key !== hk || bus.out_last !== hl)) unstable++;
            hold = 1'b0;
            if (bus.out_valid && valid_cyc < 0) valid_cyc = c;
            if (done) begin done_cyc = c; got_err = err; break; end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (c % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = rdy;
            if (bus.out_valid) begin
                if (rdy) got_q.push_back(int'(bus.out_key) * 2 + int'(bus.out_last));
                else begin hold = 1'b1; hk = bus.out_key; hl = bus.out_last; end
            end
            start = (c == inject_at);
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; desc_sel = 1'b0; bus.out_ready = 1'b0;
        root_idx = 3'd7; node_count = 3'd0;
        clear_tree();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.out_key, bus.out_last, bus.mem_rd_en, busy, done, err} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want 0", {bus.out_valid, bus.out_key, bus.out_last, bus.mem_rd_en, busy, done, err});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.out_valid, busy, done, err, bus.mem_rd_en} !== 5'd0) begin
            errors++;
            $display("FAIL reset_idle: got %b, want 0", {bus.out_valid, busy, done, err, bus.mem_rd_en});
        end
    endtask

    task automatic test_empty();
        clear_tree(); root_idx = 3'd0; node_count = 3'd0; desc_sel = 1'b0;
        run_walk(0, -1);
        checks++;
        if (done_cyc != 2) begin errors++; $display("FAIL empty_done_cycle: got %0d, want 2", done_cyc); end
        checks++;
        if (valid_cyc != -1 || got_q.size() != 0) begin
            errors++; $display("FAIL empty_no_output: got valid at %0d with %0d keys, want none", valid_cyc, got_q.size());
        end
        checks++;
        if (got_err !== 1'b0) begin errors++; $display("FAIL empty_err: got %0b, want 0", got_err); end
    endtask

    task automatic test_single();
        clear_tree(); bst_insert(0, 5); root_idx = 3'd0; node_count = 3'd1; desc_sel = 1'b0;
        run_walk(0, -1);
        checks++;
        if (valid_cyc != 6) begin errors++; $display("FAIL single_latency: got %0d, want 6", valid_cyc); end
        checks++;
        if (got_q.size() != 1 || got_q[0] != 11) begin
            errors++; $display("FAIL single_key: got %0d items first %0d, want 1 item 11 (key 5 last)", got_q.size(), (got_q.size() > 0) ? got_q[0] : -1);
        end
        checks++;
        if (done_cyc < 0 || got_err !== 1'b0) begin
            errors++; $display("FAIL single_done: got done_cyc %0d err %0b, want done and err 0", done_cyc, got_err);
        end
    endtask

    task automatic test_balanced();
        for (int d = 0; d <= (HAS_DESC ? 1 : 0); d++) begin
            build_balanced(); desc_sel = d[0];
            expect_sorted();
            run_walk(0, 10);
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++; $display("FAIL balanced_count desc=%0d: got %0d, want %0d", d, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] != exp_q[i]) begin
                    errors++; $display("FAIL balanced_item%0d desc=%0d: got key %0d last %0d, want key %0d last %0d",
                                       i, d, got_q[i] / 2, got_q[i] % 2, exp_q[i] / 2, exp_q[i] % 2);
                end
            end
            checks++;
            if (done_cyc < 0 || got_err !== 1'b0) begin
                errors++; $display("FAIL balanced_end desc=%0d: got done_cyc %0d err %0b, want done err 0", d, done_cyc, got_err);
            end
        end
    endtask

    task automatic test_stall();
        build_balanced(); desc_sel = 1'b0;
        expect_sorted();
        run_walk(1, -1);
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL stall_stable: got %0d changes, want 0", unstable); end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL stall_count: got %0d, want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] != exp_q[i]) begin
                errors++; $display("FAIL stall_item%0d: got %0d, want %0d", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_corrupt();
        for (int k = 0; k < 2; k++) begin
            clear_tree(); bst_insert(0, 9); root_idx = 3'd0; node_count = 3'd1; desc_sel = 1'b0;
            if (k == 0) t_right[0] = 3'd0; else t_left[0] = 3'd0;
            expect_walk(0, 1);
            run_walk(0, -1);
            checks++;
            if (got_err !== 1'b1 || done_cyc < 0) begin
                errors++; $display("FAIL corrupt%0d_err: got err %0b done_cyc %0d, want err 1 with done", k, got_err, done_cyc);
            end
            checks++;
            if (got_q.size() != exp_q.size()) begin
                errors++; $display("FAIL corrupt%0d_count: got %0d, want %0d", k, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] != exp_q[i]) begin
                    errors++; $display("FAIL corrupt%0d_item%0d: got %0d, want %0d", k, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit seen3 = 1'b0;
        logic [3:0] k3 = 4'd0;
        build_balanced(); desc_sel = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; bus.out_ready = 1'b1;
        for (int c = 0; c < 300 && !seen3; c++) begin
            if (bus.out_valid) begin
                if (n == 2) begin seen3 = 1'b1; bus.out_ready = 1'b0; k3 = bus.out_key; end
                else n++;
            end
            if (!seen3) @(negedge clk);
        end
        checks++;
        if (!seen3 || k3 !== 4'd3) begin errors++; $display("FAIL midrst_third: got seen %0b key %0d, want key 3", seen3, k3); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_key, bus.out_last, busy, bus.mem_rd_en, done, err} !== 10'd0) begin
            errors++; $display("FAIL midrst_async: got %b, want 0", {bus.out_valid, bus.out_key, bus.out_last, busy, bus.mem_rd_en, done, err});
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL midrst_nodone: got %0b, want 0", done); end
        expect_sorted();
        run_walk(0, -1);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL midrst_replay_count: got %0d, want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] != exp_q[i]) begin
                errors++; $display("FAIL midrst_replay%0d: got %0d, want %0d", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            clear_tree();
            desc_sel = HAS_DESC ? 1'($urandom_range(0, 1)) : 1'b0;
            if (it % 2 == 0) begin
                int n = $urandom_range(1, 7);
                int used[$];
                while (used.size() < n) begin
                    int k = $urandom_range(0, 15);
                    bit dup = 1'b0;
                    foreach (used[j]) if (used[j] == k) dup = 1'b1;
                    if (!dup) used.push_back(k);
                end
                foreach (used[j]) bst_insert(j, used[j]);
                root_idx = 3'd0; node_count = 3'(n);
                expect_sorted();
            end else begin
                for (int i = 0; i < 7; i++) begin
                    int l = $urandom_range(0, 11);
                    int r = $urandom_range(0, 11);
                    t_key[i] = 4'($urandom_range(0, 15));
                    t_left[i]  = (l > 7) ? 3'd7 : 3'(l);
                    t_right[i] = (r > 7) ? 3'd7 : 3'(r);
                end
                root_idx = 3'($urandom_range(0, 7));
                node_count = 3'($urandom_range(0, 7));
                expect_walk(int'(root_idx), int'(node_count));
            end
            run_walk(2, -1);
            checks++;
            if (done_cyc < 0 || got_err !== exp_err) begin
                errors++; $display("FAIL rand%0d_end: got done_cyc %0d err %0b, want done err %0b", it, done_cyc, got_err, exp_err);
            end
            checks++;
            if (got_q.size() != exp_q.size() || unstable != 0) begin
                errors++; $display("FAIL rand%0d_count: got %0d items unstable %0d, want %0d items stable", it, got_q.size(), unstable, exp_q.size());
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] != exp_q[i]) begin
                    errors++; $display("FAIL rand%0d_item%0d: got %0d, want %0d", it, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_single();
        test_balanced();
        test_stall();
        test_corrupt();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
